// File: rtl/tt_sweep_if.sv
// Signal bundle linking tt_sweep to its controller, result consumer and function under test.
// The master side drives start/expected/result_ready and the function output f.
interface tt_sweep_if #(parameter int N_IN = 4);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic [NV-1:0]   expected;
  logic [N_IN-1:0] vec;
  logic            f;
  logic            busy;
  logic [NV-1:0]   tt_table;
  logic [N_IN:0]   mismatch_count;
  logic [N_IN-1:0] first_fail;
  logic            match;
  logic            result_valid;
  logic            result_ready;

  modport master (
    output start, expected, f, result_ready,
    input  vec, busy, tt_table, mismatch_count, first_fail, match, result_valid
  );

  modport slave (
    input  start, expected, f, result_ready,
    output vec, busy, tt_table, mismatch_count, first_fail, match, result_valid
  );
endinterface

// File: rtl/tt_sweep.sv
// Walks every input vector of a small combinational function, captures its output into a
// truth table and reports mismatches against a latched expected word over valid/ready.
module tt_sweep #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  tt_sweep_if.slave  bus
);
  localparam int              NV   = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_RESULT
  } state_t;

  state_t          state_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic [NV-1:0]   table_q;
  logic [N_IN:0]   cnt_q;
  logic [N_IN-1:0] ff_q;
  logic            match_q;
  logic            rv_q;
  logic [3:0]      settle_q;
  logic [NV-1:0]   exp_q;
  logic            fail_seen_q;

  logic            miss_d;
  logic [N_IN:0]   cnt_d;

  // Count including the vector being sampled this cycle, so the final match sees it.
  always_comb begin
    miss_d = (bus.f != exp_q[vec_q]);
    cnt_d  = miss_d ? cnt_q + (N_IN+1)'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      table_q     <= '0;
      cnt_q       <= '0;
      ff_q        <= '0;
      match_q     <= 1'b0;
      rv_q        <= 1'b0;
      settle_q    <= '0;
      exp_q       <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          vec_q <= '0;
          if (bus.start) begin
            exp_q       <= bus.expected;
            table_q     <= '0;
            cnt_q       <= '0;
            ff_q        <= '0;
            fail_seen_q <= 1'b0;
            settle_q    <= SETTLE_W;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_q == 4'd0) begin
            state_q <= S_SAMPLE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          table_q[vec_q] <= bus.f;
          cnt_q          <= cnt_d;
          if (miss_d && !fail_seen_q) begin
            ff_q        <= vec_q;
            fail_seen_q <= 1'b1;
          end
          if (vec_q == LAST) begin
            busy_q  <= 1'b0;
            rv_q    <= 1'b1;
            match_q <= (cnt_d == '0);
            state_q <= S_RESULT;
          end else begin
            vec_q    <= vec_q + N_IN'(1);
            settle_q <= SETTLE_W;
            state_q  <= S_WAIT;
          end
        end
        S_RESULT: begin
          // start is deliberately ignored here, even on the handshake edge.
          if (bus.result_ready) begin
            rv_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = busy_q;
  assign bus.tt_table       = table_q;
  assign bus.mismatch_count = cnt_q;
  assign bus.first_fail     = ff_q;
  assign bus.match          = match_q;
  assign bus.result_valid   = rv_q;
endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench: drivers push expected results, one monitor checks every presented result.
module tb_tt_sweep;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] tbl;
    int          cnt;
    int          ff;
    logic        m;
    int          lat;
  } exp_t;

  exp_t sb[3][$];
  int   sc[3];
  bit   prev_rv[3];

  tt_sweep_if #(.N_IN(4)) b4 ();
  tt_sweep_if #(.N_IN(3)) b3a ();
  tt_sweep_if #(.N_IN(3)) b3b ();

  tt_sweep #(.N_IN(4), .SETTLE(0)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  tt_sweep #(.N_IN(3), .SETTLE(2)) u3a (.clk(clk), .rst_n(rst_n), .bus(b3a));
  tt_sweep #(.N_IN(3), .SETTLE(0)) u3b (.clk(clk), .rst_n(rst_n), .bus(b3b));

  // Function under test for the 4-input sweeper.
  assign b4.f = (b4.vec[3] & b4.vec[1]) | (b4.vec[2] & b4.vec[0]);

  function automatic logic mux3(logic [2:0] v);
    return v[2] ? v[0] : (v[1] | ~v[0]);
  endfunction

  logic r1a, r2a, r1b, r2b;
  always @(posedge clk) begin
    r1a <= mux3(b3a.vec);
    r2a <= r1a;
    r1b <= mux3(b3b.vec);
    r2b <= r1b;
  end
  assign b3a.f = r2a;
  assign b3b.f = r2b;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(int id, logic rv, logic rr, logic busy, logic [15:0] tbl,
                     logic [4:0] cnt, logic [3:0] ff, logic m);
    exp_t e;
    if (rv) begin
      if (sb[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d%0d_unexpected_result got result_valid=1 expected no result", id);
      end else begin
        e = sb[id][0];
        if (!prev_rv[id]) chk($sformatf("d%0d_latency", id), 64'(cyc - sc[id]), 64'(e.lat));
        chk($sformatf("d%0d_table", id), 64'(tbl), 64'(e.tbl));
        chk($sformatf("d%0d_mismatch_count", id), 64'(cnt), 64'(e.cnt));
        chk($sformatf("d%0d_first_fail", id), 64'(ff), 64'(e.ff));
        chk($sformatf("d%0d_match", id), 64'(m), 64'(e.m));
        chk($sformatf("d%0d_busy_in_result", id), 64'(busy), 64'(0));
        if (rr) void'(sb[id].pop_front());
      end
    end
    prev_rv[id] = rv;
  endtask

  always @(negedge clk) begin
    mon(0, b4.result_valid, b4.result_ready, b4.busy, b4.tt_table,
        b4.mismatch_count, b4.first_fail, b4.match);
    mon(1, b3a.result_valid, b3a.result_ready, b3a.busy, {8'h00, b3a.tt_table},
        {1'b0, b3a.mismatch_count}, {1'b0, b3a.first_fail}, b3a.match);
    mon(2, b3b.result_valid, b3b.result_ready, b3b.busy, {8'h00, b3b.tt_table},
        {1'b0, b3b.mismatch_count}, {1'b0, b3b.first_fail}, b3b.match);
  end

  function automatic exp_t mk(logic [15:0] t, int c, int f, logic m, int l);
    exp_t e;
    e.tbl = t; e.cnt = c; e.ff = f; e.m = m; e.lat = l;
    return e;
  endfunction

  // Start pulse accepted at the second edge; expected is scrambled right after to prove latching.
  task automatic start4(logic [15:0] w);
    @(posedge clk); #1;
    b4.expected = w;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b4.expected = ~w;
    sc[0] = cyc;
  endtask

  task automatic start3(logic [7:0] w);
    @(posedge clk); #1;
    b3a.expected = w; b3b.expected = w;
    b3a.start = 1'b1; b3b.start = 1'b1;
    @(posedge clk); #1;
    b3a.start = 1'b0; b3b.start = 1'b0;
    b3a.expected = ~w; b3b.expected = ~w;
    sc[1] = cyc; sc[2] = cyc;
  endtask

  task automatic wait_empty(int id);
    int n = 0;
    while (sb[id].size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb[id].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL d%0d_timeout got %0d pending results expected 0", id, sb[id].size());
      sb[id].delete();
    end
    #1;
  endtask

  task automatic chk_b4_zero(string tag);
    chk({tag, "_vec"}, 64'(b4.vec), 64'(0));
    chk({tag, "_busy"}, 64'(b4.busy), 64'(0));
    chk({tag, "_table"}, 64'(b4.tt_table), 64'(0));
    chk({tag, "_mismatch_count"}, 64'(b4.mismatch_count), 64'(0));
    chk({tag, "_first_fail"}, 64'(b4.first_fail), 64'(0));
    chk({tag, "_match"}, 64'(b4.match), 64'(0));
    chk({tag, "_result_valid"}, 64'(b4.result_valid), 64'(0));
  endtask

  initial begin
    b4.start = 1'b0;  b4.expected = '0;  b4.result_ready = 1'b1;
    b3a.start = 1'b0; b3a.expected = '0; b3a.result_ready = 1'b1;
    b3b.start = 1'b0; b3b.expected = '0; b3b.result_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1 chk_b4_zero("reset");
    chk("reset_d1_result_valid", 64'(b3a.result_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Matching sweep, then single-bit and fully inverted expectations.
    sb[0].push_back(mk(16'hECA0, 0, 0, 1'b1, 32));
    start4(16'hECA0);
    chk("start_busy", 64'(b4.busy), 64'(1));
    chk("start_vec", 64'(b4.vec), 64'(0));
    wait_empty(0);

    sb[0].push_back(mk(16'hECA0, 1, 0, 1'b0, 32));
    start4(16'hECA1);
    wait_empty(0);

    sb[0].push_back(mk(16'hECA0, 1, 7, 1'b0, 32));
    start4(16'hEC20);
    wait_empty(0);

    sb[0].push_back(mk(16'hECA0, 16, 0, 1'b0, 32));
    start4(16'h135F);
    wait_empty(0);

    // Two-register-delayed mux: SETTLE=2 captures correctly, SETTLE=0 sees the previous vector.
    sb[1].push_back(mk(16'h00AD, 0, 0, 1'b1, 32));
    sb[2].push_back(mk(16'h005B, 6, 1, 1'b0, 16));
    start3(8'hAD);
    wait_empty(2);
    wait_empty(1);

    // Consumer stalls in RESULT while start is pulsed; the monitor checks stability each cycle.
    b4.result_ready = 1'b0;
    sb[0].push_back(mk(16'hECA0, 0, 0, 1'b1, 32));
    start4(16'hECA0);
    begin
      int n = 0;
      while (!b4.result_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("stall_result_valid", 64'(b4.result_valid), 64'(1));
    for (int k = 0; k < 5; k++) begin
      b4.start = (k == 2);
      b4.expected = 16'h0000;
      @(posedge clk); #1;
    end
    b4.start = 1'b0;
    chk("stall_still_valid", 64'(b4.result_valid), 64'(1));
    b4.result_ready = 1'b1;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    chk("handshake_valid_low", 64'(b4.result_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("no_new_sweep_busy", 64'(b4.busy), 64'(0));
    chk("idle_vec", 64'(b4.vec), 64'(0));
    chk("idle_table_kept", 64'(b4.tt_table), 64'(16'hECA0));
    chk("idle_match_kept", 64'(b4.match), 64'(1));
    wait_empty(0);

    // Asynchronous reset mid-sweep, then a full recovery sweep.
    start4(16'hECA0);
    begin
      int n = 0;
      while (b4.vec != 4'd7 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("midsweep_vec", 64'(b4.vec), 64'(7));
    #2 rst_n = 1'b0;
    #1 chk_b4_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    sb[0].push_back(mk(16'hECA0, 0, 0, 1'b1, 32));
    start4(16'hECA0);
    wait_empty(0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
